// File: rtl/alu_pkg.sv
// Shared types for the ALU accumulator: function codes and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        FN_ADD = 2'd0,
        FN_OR  = 2'd1,
        FN_AND = 2'd2,
        FN_CAT = 2'd3
    } fn_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational 4-function ALU: add, OR-reduce, AND-reduce, concat; 2N-bit result.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  fn_t            fn,
    output logic [2*N-1:0] result_c
);

    localparam int unsigned W = 2 * N;

    // Select the function result; reductions are zero-extended to the full width.
    always_comb begin
        result_c = '0;
        case (fn)
            FN_ADD:  result_c = W'(a) + W'(b);
            FN_OR:   result_c = W'((|a) | (|b));
            FN_AND:  result_c = W'((&a) & (&b));
            FN_CAT:  result_c = {a, b};
            default: result_c = '0;
        endcase
    end

endmodule : alu_core

// File: rtl/alu_accumulator.sv
// ALU accumulator: latches operand/function on Start, computes with the
// accumulator low half as B, writes back and pulses Done.
// Optional sticky add-carry flag enabled by macro ALU_ACC_OVF_EN.
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Clear,
    input  logic [N-1:0]     Data,
    input  logic [1:0]       Function,
    output logic [2*N-1:0]   ALUout,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] OpCount,
    output logic             Ovf
);

    localparam int unsigned W = 2 * N;

    state_t           state;
    logic [N-1:0]     a_q;
    fn_t              f_q;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     result_c;
    logic             accept_c;

    alu_core #(.N(N)) u_core (
        .a        (a_q),
        .b        (acc[N-1:0]),
        .fn       (f_q),
        .result_c (result_c)
    );

    // IDLE and DONE share the same accept/clear behaviour.
    assign accept_c = (state == S_IDLE) || (state == S_DONE);

    // FSM, operand latches, accumulator and completed-operation counter.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            a_q   <= '0;
            f_q   <= FN_ADD;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Clear) begin
                        acc   <= '0;
                        state <= S_IDLE;
                    end else if (Start) begin
                        a_q   <= Data;
                        f_q   <= fn_t'(Function);
                        state <= S_EXEC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    acc   <= result_c;
                    cnt   <= cnt + CNT_W'(1);
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ACC_OVF_EN
    logic ovf_q;

    // Sticky carry out of the N-bit field on add; cleared only by Clear or Reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ovf_q <= 1'b0;
        end else if (accept_c && Clear) begin
            ovf_q <= 1'b0;
        end else if ((state == S_EXEC) && (f_q == FN_ADD)) begin
            ovf_q <= ovf_q | result_c[N];
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

    assign ALUout  = acc;
    assign OpCount = cnt;
    assign Busy    = (state == S_EXEC);
    assign Done    = (state == S_DONE);

endmodule : alu_accumulator
